pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage f-d-e-m-w pipeline-register chain.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_div_seq.sv | 82 ++++++++
 rtl/pipe_hazard_ctrl.sv | 70 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-number
// width, the divider sequencer state encoding and a source-match helper.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // True when an instruction reads a source register that matches the producer's destination.
    function automatic logic src_hit(input logic use_src, input reg_addr_t src, input reg_addr_t dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Status/control bundle between the pipeline stage registers (master)
// and the central stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             d_valid;
    reg_addr_t        d_rs;
    reg_addr_t        d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic             e_valid;
    reg_addr_t        e_wreg_addr;
    logic             e_regen;
    logic             e_is_load;
    logic             e_sig_div;
    logic             e_advance;
    logic             m_valid;
    logic             m_exc;
    logic             m_eret;

    logic             f_stall;
    logic             d_stall;
    logic             e_stall;
    logic             m_stall;
    logic             flush;
    logic             div_start;
    logic             div_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
               e_valid, e_wreg_addr, e_regen, e_is_load, e_sig_div, e_advance,
               m_valid, m_exc, m_eret,
        input  f_stall, d_stall, e_stall, m_stall, flush,
               div_start, div_done, stall_cycles
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt,
               e_valid, e_wreg_addr, e_regen, e_is_load, e_sig_div, e_advance,
               m_valid, m_exc, m_eret,
        output f_stall, d_stall, e_stall, m_stall, flush,
               div_start, div_done, stall_cycles
    );

endinterface

// File: rtl/pipe_div_seq.sv
// Divider occupancy sequencer: holds E for DIV_CYCLES cycles from launch,
// pulses div_done once, then waits for E to hand the result off.
module pipe_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33
)
(
    input  logic clk,
    input  logic resetn,
    input  logic start_req,
    input  logic flush,
    input  logic e_advance,
    output logic busy,
    output logic div_start,
    output logic div_done
);

    localparam int CW = $clog2(DIV_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          done_first;
    logic          done_first_nxt;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        done_first_nxt = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start_req && !flush) begin
                    state_nxt = DIV_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    state_nxt = DIV_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt      = DIV_DONE;
                    cnt_nxt        = '0;
                    done_first_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_LAST;
                end
            end
            // Staying here until E hands off keeps the same div from re-arming.
            DIV_DONE: begin
                if (flush || e_advance) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: begin
                state_nxt = DIV_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= DIV_IDLE;
            cnt        <= '0;
            done_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            done_first <= done_first_nxt;
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign div_start = (state == DIV_IDLE) && start_req && !flush;
    assign div_done  = done_first && !flush;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D/E/M stage registers: load-use
// detection, divider occupancy, exception/eret flush and a stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 32
)
(
    input  logic              clk,
    input  logic              resetn,
    pipe_hazard_ctrl_if.slave bus
);

    logic             flush_i;
    logic             load_use;
    logic             d_stall_i;
    logic             start_req;
    logic             div_busy;
    logic             div_start_i;
    logic             div_done_i;
    logic             e_stall_i;
    logic             any_stall;
    logic [CNT_W-1:0] stall_cnt;

    // Every output is held low while reset is asserted, even with live inputs.
    assign flush_i = resetn && bus.m_valid && (bus.m_exc || bus.m_eret);

    assign load_use = bus.d_valid && bus.e_valid && bus.e_is_load && bus.e_regen
                      && (bus.e_wreg_addr != REG_ZERO)
                      && (src_hit(bus.d_use_rs, bus.d_rs, bus.e_wreg_addr)
                          || src_hit(bus.d_use_rt, bus.d_rt, bus.e_wreg_addr));

    assign d_stall_i = resetn && load_use && !flush_i;
    assign start_req = resetn && bus.e_valid && bus.e_sig_div;

    pipe_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk       (clk),
        .resetn    (resetn),
        .start_req (start_req),
        .flush     (flush_i),
        .e_advance (bus.e_advance),
        .busy      (div_busy),
        .div_start (div_start_i),
        .div_done  (div_done_i)
    );

    assign e_stall_i = (div_busy || div_start_i) && !flush_i;
    assign any_stall = d_stall_i || e_stall_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (any_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.f_stall      = d_stall_i;
    assign bus.d_stall      = d_stall_i;
    assign bus.e_stall      = e_stall_i;
    assign bus.m_stall      = 1'b0;
    assign bus.flush        = flush_i;
    assign bus.div_start    = div_start_i;
    assign bus.div_done     = div_done_i;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: an age-based reference model is
// compared with the DUT on every falling edge, plus hand-computed pins.
module tb_pipe_hazard_ctrl;

    localparam int DIV     = 33;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic resetn;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .DIV_CYCLES (DIV),
        .CNT_W      (CW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: age of the div in E (-1 none, 1..DIV-1 stalling, DIV done pulse, DIV+1 waiting).
    int age   = -1;
    int m_cnt = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_outputs(output logic fl, output logic d, output logic e,
                                 output logic st, output logic dn);
        logic lu;
        fl = resetn && bus.m_valid && (bus.m_exc || bus.m_eret);
        lu = bus.d_valid && bus.e_valid && bus.e_is_load && bus.e_regen && (bus.e_wreg_addr != 5'd0)
             && ((bus.d_use_rs && bus.d_rs == bus.e_wreg_addr) || (bus.d_use_rt && bus.d_rt == bus.e_wreg_addr));
        d  = resetn && lu && !fl;
        st = resetn && (age < 0) && bus.e_valid && bus.e_sig_div && !fl;
        e  = resetn && !fl && (st || (age >= 1 && age < DIV));
        dn = resetn && !fl && (age == DIV);
    endtask

    always @(posedge clk or negedge resetn) begin
        logic fl, d, e, st, dn;
        if (!resetn) begin
            age   = -1;
            m_cnt = 0;
        end else begin
            model_outputs(fl, d, e, st, dn);
            if ((d || e) && m_cnt < CNT_MAX) m_cnt++;
            if (fl) age = -1;
            else if (age < 0) begin
                if (st) age = 1;
            end else if (age >= DIV) age = bus.e_advance ? -1 : DIV + 1;
            else age++;
        end
    end

    always @(negedge clk) begin
        logic fl, d, e, st, dn;
        model_outputs(fl, d, e, st, dn);
        check_output("f_stall", 32'(bus.f_stall), 32'(d));
        check_output("d_stall", 32'(bus.d_stall), 32'(d));
        check_output("e_stall", 32'(bus.e_stall), 32'(e));
        check_output("m_stall", 32'(bus.m_stall), 32'd0);
        check_output("flush", 32'(bus.flush), 32'(fl));
        check_output("div_start", 32'(bus.div_start), 32'(st));
        check_output("div_done", 32'(bus.div_done), 32'(dn));
        check_output("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.d_valid = 0; bus.d_rs = 0; bus.d_rt = 0; bus.d_use_rs = 0; bus.d_use_rt = 0;
        bus.e_valid = 0; bus.e_wreg_addr = 0; bus.e_regen = 0; bus.e_is_load = 0;
        bus.e_sig_div = 0; bus.e_advance = 0;
        bus.m_valid = 0; bus.m_exc = 0; bus.m_eret = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic apply_stimulus(input logic dv, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt, input logic [4:0] wa,
                                  input logic regen, input logic ld);
        bus.d_valid = dv; bus.d_rs = rs; bus.d_rt = rt; bus.d_use_rs = urs; bus.d_use_rt = urt;
        bus.e_valid = 1'b1; bus.e_wreg_addr = wa; bus.e_regen = regen; bus.e_is_load = ld;
    endtask

    task automatic observe(input int n, output int stalls, output int starts, output int dones,
                           output int first_start, output int first_done);
        stalls = 0; starts = 0; dones = 0; first_start = -1; first_done = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.e_stall) stalls++;
            if (bus.div_start) begin
                starts++;
                if (first_start < 0) first_start = k;
            end
            if (bus.div_done) begin
                dones++;
                if (first_done < 0) first_done = k;
            end
            next_cycle();
        end
    endtask

    task automatic start_div();
        bus.e_valid   = 1'b1;
        bus.e_sig_div = 1'b1;
        bus.e_advance = 1'b0;
    endtask

    initial begin
        int stalls, starts, dones, fs, fd;

        // Reset with live hazard, div and exception inputs: outputs must stay quiet.
        resetn = 1'b0;
        clear_inputs();
        next_cycle();
        apply_stimulus(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1);
        bus.e_sig_div = 1; bus.m_valid = 1; bus.m_exc = 1;
        @(negedge clk);
        check_output("rst_d_stall", 32'(bus.d_stall), 32'd0);
        check_output("rst_div_start", 32'(bus.div_start), 32'd0);
        check_output("rst_flush", 32'(bus.flush), 32'd0);
        check_output("rst_cnt", 32'(bus.stall_cycles), 32'd0);
        next_cycle();
        clear_inputs();
        resetn = 1'b1;
        next_cycle();

        // Load-use through rs, then E advances past the load.
        apply_stimulus(1, 5'd5, 5'd2, 1, 1, 5'd5, 1, 1);
        @(negedge clk);
        check_output("lu_rs_d", 32'(bus.d_stall), 32'd1);
        check_output("lu_rs_f", 32'(bus.f_stall), 32'd1);
        next_cycle();
        apply_stimulus(1, 5'd7, 5'd2, 1, 1, 5'd5, 1, 0);
        @(negedge clk);
        check_output("lu_after_adv", 32'(bus.d_stall), 32'd0);
        next_cycle();
        apply_stimulus(1, 5'd3, 5'd9, 0, 1, 5'd9, 1, 1);
        @(negedge clk);
        check_output("lu_rt", 32'(bus.d_stall), 32'd1);
        next_cycle();
        apply_stimulus(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1);
        @(negedge clk);
        check_output("lu_r0", 32'(bus.d_stall), 32'd0);
        next_cycle();
        apply_stimulus(1, 5'd7, 5'd7, 0, 0, 5'd7, 1, 1);
        @(negedge clk);
        check_output("lu_nouse", 32'(bus.d_stall), 32'd0);
        next_cycle();
        apply_stimulus(1, 5'd7, 5'd1, 1, 0, 5'd7, 0, 1);
        @(negedge clk);
        check_output("lu_noregen", 32'(bus.d_stall), 32'd0);
        next_cycle();
        apply_stimulus(1, 5'd8, 5'd1, 1, 0, 5'd8, 1, 1);
        bus.m_valid = 1; bus.m_eret = 1;
        @(negedge clk);
        check_output("flush_eret", 32'(bus.flush), 32'd1);
        check_output("flush_over_lu", 32'(bus.d_stall), 32'd0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Full divide, result held in E for six extra cycles before hand-off.
        do_reset();
        start_div();
        observe(DIV + 6, stalls, starts, dones, fs, fd);
        check_output("div_stall_len", 32'(stalls), 32'd33);
        check_output("div_start_at", 32'(fs), 32'd0);
        check_output("div_starts", 32'(starts), 32'd1);
        check_output("div_done_at", 32'(fd), 32'd33);
        check_output("div_dones", 32'(dones), 32'd1);
        bus.e_advance = 1'b1;
        @(negedge clk);
        check_output("div_adv_nostart", 32'(bus.div_start), 32'd0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Exception in M while the div is at cycle 10.
        do_reset();
        start_div();
        observe(10, stalls, starts, dones, fs, fd);
        bus.m_valid = 1; bus.m_exc = 1;
        @(negedge clk);
        check_output("fl_mid_flush", 32'(bus.flush), 32'd1);
        check_output("fl_mid_estall", 32'(bus.e_stall), 32'd0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check_output("fl_mid_clear", 32'(bus.flush), 32'd0);
        next_cycle();
        observe(40, stalls, starts, dones, fs, fd);
        check_output("fl_no_stall", 32'(stalls), 32'd0);
        check_output("fl_no_done", 32'(dones), 32'd0);

        // Reset pulled at cycle 7 of the div, then a fresh div after release.
        do_reset();
        start_div();
        observe(7, stalls, starts, dones, fs, fd);
        resetn = 1'b0;
        #1;
        check_output("rstmid_e_stall", 32'(bus.e_stall), 32'd0);
        check_output("rstmid_div_start", 32'(bus.div_start), 32'd0);
        check_output("rstmid_div_done", 32'(bus.div_done), 32'd0);
        check_output("rstmid_cnt", 32'(bus.stall_cycles), 32'd0);
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        observe(DIV + 2, stalls, starts, dones, fs, fd);
        check_output("rstmid_stall_len", 32'(stalls), 32'd33);
        check_output("rstmid_done_at", 32'(fd), 32'd33);
        check_output("rstmid_starts", 32'(starts), 32'd1);
        bus.e_advance = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();

        // Twenty back-to-back load-use stalls saturate the 4-bit counter.
        do_reset();
        apply_stimulus(1, 5'd4, 5'd0, 1, 0, 5'd4, 1, 1);
        repeat (15) next_cycle();
        @(negedge clk);
        check_output("sat_reach", 32'(bus.stall_cycles), 32'd15);
        repeat (5) next_cycle();
        @(negedge clk);
        check_output("sat_hold", 32'(bus.stall_cycles), 32'd15);
        check_output("sat_still_stall", 32'(bus.d_stall), 32'd1);
        next_cycle();
        clear_inputs();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
